// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshake, iterative shifts and a persistent {carry, zero} flag register
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] result_q, work_q, res_d, sh_d;
  logic [1:0]       flags_q, flg_d;
  logic [SW-1:0]    cnt_q, amt;
  logic             shr_q, sh_out, is_shift;
  logic [WIDTH:0]   sum;
  assign amt       = data_b[SW-1:0];
  assign sum       = {1'b0, data_a} + {1'b0, data_b};
  assign is_shift  = alu_op == 3'b101 || alu_op == 3'b110;
  assign sh_d      = shr_q ? work_q >> 1 : work_q << 1;
  assign sh_out    = shr_q ? work_q[0] : work_q[WIDTH-1];
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign flags     = flags_q;
  // Result of any op that completes on the accept edge, including zero-amount shifts
  always_comb begin
    res_d = '0;
    flg_d = flags_q;
    case (alu_op)
      3'b000: begin
        res_d = sum[WIDTH-1:0];
        flg_d = {sum[WIDTH], sum[WIDTH-1:0] == '0};
      end
      3'b001: res_d = ~(data_a & data_b);
      3'b010: flg_d[0] = data_a == data_b;
      3'b011: begin
        res_d    = sum[WIDTH-1:0];
        flg_d[0] = sum[WIDTH-1:0] == '0;
      end
      3'b100: begin
        res_d = data_a - data_b;
        flg_d = {data_a >= data_b, data_a == data_b};
      end
      3'b101, 3'b110: begin
        res_d    = data_a;
        flg_d[0] = data_a == '0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= 2'b00;
      work_q   <= '0;
      cnt_q    <= '0;
      shr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          work_q <= data_a;
          cnt_q  <= amt;
          shr_q  <= alu_op == 3'b110;
          if (is_shift && amt != '0) state_q <= EXEC;
          else begin
            state_q  <= DONE;
            result_q <= res_d;
            flags_q  <= flg_d;
          end
        end
        EXEC: begin
          work_q <= sh_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) begin
            state_q  <= DONE;
            result_q <= sh_d;
            flags_q  <= {sh_out, sh_d == '0};
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 16;
  logic         clk = 1'b0, rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [2:0]   alu_op;
  logic [W-1:0] data_a, data_b, result;
  logic [1:0]   flags;
  logic [1:0]   mf;
  int vectors = 0, errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    logic [1:0]   f;
    int           lat;
  } vec_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .data_a(data_a), .data_b(data_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: result from plain arithmetic, flags kept in mf, latency = edges after accept
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output int lat);
    int n;
    logic [W:0] s;
    n = int'(b[3:0]);
    s = {1'b0, a} + {1'b0, b};
    r = '0;
    lat = 0;
    case (op)
      3'd0: begin r = s[W-1:0]; mf = {s[W], r == 0}; end
      3'd1: r = ~(a & b);
      3'd2: mf[0] = a == b;
      3'd3: begin r = s[W-1:0]; mf[0] = r == 0; end
      3'd4: begin r = a - b; mf = {a >= b, r == 0}; end
      3'd5: begin r = a << n; if (n > 0) mf[1] = a[W-n]; mf[0] = r == 0; lat = n; end
      3'd6: begin r = a >> n; if (n > 0) mf[1] = a[n-1]; mf[0] = r == 0; lat = n; end
      default: r = '0;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op = op; data_a = a; data_b = b; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1 lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; data_a = '0; data_b = '0;
    mf = 2'b00;
    @(posedge clk); #1;
    vectors++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
    vectors++; if (flags !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", flags); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t tbl [12] = '{
      '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 2'b11, 0},
      '{3'd2, 16'h1234, 16'h1234, 16'h0000, 2'b11, 0},
      '{3'd2, 16'h0001, 16'h0002, 16'h0000, 2'b10, 0},
      '{3'd4, 16'h0005, 16'h0007, 16'hFFFE, 2'b00, 0},
      '{3'd4, 16'h0007, 16'h0007, 16'h0000, 2'b11, 0},
      '{3'd5, 16'h8001, 16'h0004, 16'h0010, 2'b00, 4},
      '{3'd6, 16'h0003, 16'h0001, 16'h0001, 2'b10, 1},
      '{3'd3, 16'hFFFF, 16'h0001, 16'h0000, 2'b11, 0},
      '{3'd7, 16'h1234, 16'h5678, 16'h0000, 2'b11, 0},
      '{3'd5, 16'h00F0, 16'h0000, 16'h00F0, 2'b10, 0},
      '{3'd6, 16'h8000, 16'h000F, 16'h0001, 2'b00, 15},
      '{3'd1, 16'hFFFF, 16'hFFFF, 16'h0000, 2'b00, 0}
    };
    int lat;
    logic rdy_bad;
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      lat = 0; rdy_bad = 1'b0;
      while (!out_valid && lat < 64) begin
        if (in_ready || !busy) rdy_bad = 1'b1;
        @(posedge clk); #1 lat++;
      end
      if (in_ready) rdy_bad = 1'b1;
      vectors++; if (lat != tbl[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tbl[i].lat); end
      vectors++; if (result !== tbl[i].r) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, result, tbl[i].r); end
      vectors++; if (flags !== tbl[i].f) begin errors++; $display("FAIL dir%0d_flags: got %b want %b", i, flags, tbl[i].f); end
      vectors++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL dir%0d_in_ready_low: got %b want 0", i, rdy_bad); end
      mf = tbl[i].f;
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] er;
    int el, lat;
    model(3'd1, 16'hFF00, 16'h0F0F, er, el);
    issue(3'd1, 16'hFF00, 16'h0F0F);
    wait_done(lat);
    vectors++; if (result !== 16'hF0FF) begin errors++; $display("FAIL bp_result: got %h want f0ff", result); end
    for (int i = 0; i < 3; i++) begin
      alu_op = 3'd0; data_a = 16'(($urandom)); data_b = 16'(($urandom)); in_valid = 1'b1;
      @(posedge clk); #1;
      vectors++; if (result !== er) begin errors++; $display("FAIL bp_hold_result%0d: got %h want %h", i, result, er); end
      vectors++; if (flags !== mf) begin errors++; $display("FAIL bp_hold_flags%0d: got %b want %b", i, flags, mf); end
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready%0d: got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    issue(3'd5, 16'h0001, 16'd10);
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (result !== '0) begin errors++; $display("FAIL mid_rst_result: got %h want 0000", result); end
    vectors++; if (flags !== 2'b00) begin errors++; $display("FAIL mid_rst_flags: got %b want 00", flags); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    @(posedge clk); #1 rst = 1'b0;
    mf = 2'b00;
    issue(3'd0, 16'd2, 16'd3);
    wait_done(lat);
    vectors++; if (lat != 0) begin errors++; $display("FAIL post_rst_latency: got %0d want 0", lat); end
    vectors++; if (result !== 16'h0005) begin errors++; $display("FAIL post_rst_result: got %h want 0005", result); end
    vectors++; if (flags !== 2'b00) begin errors++; $display("FAIL post_rst_flags: got %b want 00", flags); end
    consume();
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [W-1:0] a, b, er;
    int el, lat;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 4) == 0) a = 16'hFFFF;
      if ($urandom_range(0, 4) == 0) b = a;
      if ($urandom_range(0, 5) == 0) b = 16'h0000;
      model(op, a, b, er, el);
      issue(op, a, b);
      wait_done(lat);
      vectors++; if (lat != el) begin errors++; $display("FAIL rnd%0d_latency op=%0d a=%h b=%h: got %0d want %0d", i, op, a, b, lat, el); end
      vectors++; if (result !== er) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, result, er); end
      vectors++; if (flags !== mf) begin errors++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h: got %b want %b", i, op, a, b, flags, mf); end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-op 16-bit datapath ALU.
- Widens operands to WIDTH bits and adds SUB, SHL and SHR ops; shifts are iterative multi-cycle.
- Accepts one operation at a time through a valid/ready handshake and holds the result until the consumer takes it.
- Keeps a persistent {carry, zero} flag register for the control unit's branch logic.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4). SW = $clog2(WIDTH) is derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request; equals (state==IDLE).
- alu_op  input  3  operation code, sampled on accept.
- data_a  input  WIDTH  operand A, sampled on accept.
- data_b  input  WIDTH  operand B; for shifts, shift amount = data_b[SW-1:0].
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- flags  output  2  registered flags: bit1 = carry, bit0 = zero.
- busy  output  1  high in EXEC or DONE (i.e. !in_ready).

Behaviour:
- Reset, async, immediate: state=IDLE, result=0, flags=2'b00, out_valid=0, in_ready=1, busy=0, shift counter=0. Reset in any state, including mid-shift, aborts the operation; no result is produced.
- Accept: rising edge with in_valid && in_ready. Operands and op are latched. in_valid while !in_ready is ignored.
- States:
  - IDLE --accept single-cycle op--> DONE.
  - IDLE --accept shift, amount 0--> DONE.
  - IDLE --accept shift, amount n>0--> EXEC.
  - EXEC --counter reaches 0--> DONE.
  - DONE --out_ready--> IDLE.
- Single-cycle ops: result/flags written on the accept edge; out_valid high from the next cycle (latency 1).
- Shifts: counter loaded with n on accept. Each EXEC edge shifts the working register by 1 and decrements the counter. The edge that reaches 0 enters DONE. out_valid rises n edges after the accept edge.
- Op encodings (flags not listed are retained unchanged):
  - 000 ADD: {carry,result}=A+B (WIDTH+1 bits); zero=(result==0).
  - 001 NAND: result=~(A&B); flags unchanged.
  - 010 EQ: result=0; zero=(A==B); carry unchanged.
  - 011 ADDM: result=A+B mod 2^WIDTH; zero updated; carry unchanged.
  - 100 SUB: result=A-B mod 2^WIDTH; carry=(A>=B) unsigned, i.e. no-borrow; zero updated.
  - 101 SHL: logical left by n, zero fill; carry = last bit shifted out (unchanged if n=0); zero updated.
  - 110 SHR: logical right by n; carry = last bit shifted out (unchanged if n=0); zero updated.
  - 111 reserved: result=0; flags unchanged; completes like a single-cycle op.
- DONE: result, flags and out_valid held stable while out_ready=0. On an edge with out_ready=1, out_valid drops and state returns to IDLE. No new accept in that same edge, so peak throughput is 1 op per 2 cycles.
- result and flags keep their last values in IDLE/EXEC; only the DONE entry edge updates them.
- Shift amount n ranges 0..WIDTH-1; there is no clamping.

Test Plan:
- ADD A=0xFFFF, B=0x0001 -> result=0x0000, flags=2'b11, out_valid high 1 cycle after accept.
- Then EQ A=0x1234, B=0x1234 -> result=0x0000, flags=2'b11 (carry retained); next EQ A=1, B=2 -> flags=2'b10.
- SUB A=0x0005, B=0x0007 -> result=0xFFFE, flags=2'b00; SUB A=7, B=7 -> 0x0000, flags=2'b11.
- SHL A=0x8001, B=4 -> result=0x0010, carry=0, zero=0, out_valid 4 edges after accept, in_ready=0 throughout. SHR A=0x0003, B=1 -> 0x0001, carry=1.
- Backpressure: finish NAND A=0xFF00, B=0x0F0F (result 0xF0FF) with out_ready=0 for 3 cycles -> result, flags and out_valid stable; in_valid pulses ignored; in_ready=1 the cycle after out_ready=1.
- Assert rst during EXEC of SHL by 10 -> outputs immediately 0, flags=00, in_ready=1; a fresh ADD 2+3 after release -> 0x0005, flags=00.
